// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe game controller: cursor, 9-cell board, turn alternation,
// win/draw detection and a free-running cursor blink strobe.
module ttt_game_ctrl #(
  parameter logic [1:0]  FIRST_PLAYER = 2'b01,
  parameter int unsigned BLINK_DIV    = 25_000_000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            move_next,
  input  logic            move_prev,
  input  logic            place,
  input  logic            restart,
  output logic [3:0]      currentCell,
  output logic [8:0][1:0] currentGame,
  output logic [1:0]      turn,
  output logic [1:0]      winner,
  output logic            game_over,
  output logic            cursor_blink
);

  typedef enum logic [1:0] {
    S_PLAY  = 2'd0,
    S_CHECK = 2'd1,
    S_OVER  = 2'd2
  } state_t;

  localparam logic [25:0] BLINK_TC  = 26'(BLINK_DIV - 1);
  localparam logic [3:0]  LAST_CELL = 4'd8;
  localparam logic [3:0]  MAX_MOVES = 4'd9;

  state_t            state_q;
  logic [3:0]        cell_q;
  logic [3:0]        cell_d;
  logic [8:0][1:0]   board_q;
  logic [1:0]        turn_q;
  logic [1:0]        winner_q;
  logic              over_q;
  logic [3:0]        count_q;
  logic [25:0]       blink_cnt_q;
  logic [25:0]       blink_cnt_d;
  logic              blink_q;
  logic              line_win;
  logic              cell_free;
  logic [1:0]        turn_other;

  function automatic logic line3(input logic [1:0] a, input logic [1:0] b,
                                 input logic [1:0] c, input logic [1:0] m);
    return (a == m) && (b == m) && (c == m);
  endfunction

  // The mark just placed is still turn_q while in CHECK, so lines are tested against it.
  always_comb begin
    line_win = line3(board_q[0], board_q[1], board_q[2], turn_q) |
               line3(board_q[3], board_q[4], board_q[5], turn_q) |
               line3(board_q[6], board_q[7], board_q[8], turn_q) |
               line3(board_q[0], board_q[3], board_q[6], turn_q) |
               line3(board_q[1], board_q[4], board_q[7], turn_q) |
               line3(board_q[2], board_q[5], board_q[8], turn_q) |
               line3(board_q[0], board_q[4], board_q[8], turn_q) |
               line3(board_q[2], board_q[4], board_q[6], turn_q);
  end

  always_comb begin
    cell_free  = (board_q[cell_q] == 2'b00);
    turn_other = (turn_q == 2'b01) ? 2'b10 : 2'b01;
    cell_d     = cell_q;
    if (move_next && !move_prev) begin
      cell_d = (cell_q >= LAST_CELL) ? 4'd0 : cell_q + 4'd1;
    end else if (move_prev && !move_next) begin
      cell_d = (cell_q == 4'd0) ? LAST_CELL : cell_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_PLAY;
      cell_q   <= '0;
      board_q  <= '0;
      turn_q   <= FIRST_PLAYER;
      winner_q <= '0;
      over_q   <= 1'b0;
      count_q  <= '0;
    end else if (restart) begin
      state_q  <= S_PLAY;
      cell_q   <= '0;
      board_q  <= '0;
      turn_q   <= FIRST_PLAYER;
      winner_q <= '0;
      over_q   <= 1'b0;
      count_q  <= '0;
    end else begin
      case (state_q)
        S_PLAY: begin
          // place outranks movement even when the target cell is occupied
          if (place) begin
            if (cell_free) begin
              board_q[cell_q] <= turn_q;
              count_q         <= (count_q >= MAX_MOVES) ? MAX_MOVES : count_q + 4'd1;
              state_q         <= S_CHECK;
            end
          end else begin
            cell_q <= cell_d;
          end
        end
        S_CHECK: begin
          if (line_win) begin
            winner_q <= turn_q;
            over_q   <= 1'b1;
            state_q  <= S_OVER;
          end else if (count_q == MAX_MOVES) begin
            winner_q <= 2'b00;
            over_q   <= 1'b1;
            state_q  <= S_OVER;
          end else begin
            turn_q  <= turn_other;
            state_q <= S_PLAY;
          end
        end
        S_OVER: begin
          state_q <= S_OVER;
        end
        default: begin
          state_q <= S_PLAY;
        end
      endcase
    end
  end

  always_comb begin
    blink_cnt_d = (blink_cnt_q == BLINK_TC) ? '0 : blink_cnt_q + 26'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      if (blink_cnt_q == BLINK_TC) begin
        blink_q <= ~blink_q;
      end
    end
  end

  assign currentCell  = cell_q;
  assign currentGame  = board_q;
  assign turn         = turn_q;
  assign winner       = winner_q;
  assign game_over    = over_q;
  assign cursor_blink = blink_q;

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Bench for ttt_game_ctrl: directed game scenarios checked against a
// rule-level game model every cycle, plus literal spot checks.
module tb_ttt_game_ctrl;

  localparam int unsigned BDIV = 4;
  localparam logic [1:0]  FP   = 2'b01;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            move_next = 1'b0;
  logic            move_prev = 1'b0;
  logic            place = 1'b0;
  logic            restart = 1'b0;
  logic [3:0]      currentCell;
  logic [8:0][1:0] currentGame;
  logic [1:0]      turn;
  logic [1:0]      winner;
  logic            game_over;
  logic            cursor_blink;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  ttt_game_ctrl #(
    .FIRST_PLAYER(FP),
    .BLINK_DIV(BDIV)
  ) dut (
    .clk(clk),
    .reset(reset),
    .move_next(move_next),
    .move_prev(move_prev),
    .place(place),
    .restart(restart),
    .currentCell(currentCell),
    .currentGame(currentGame),
    .turn(turn),
    .winner(winner),
    .game_over(game_over),
    .cursor_blink(cursor_blink)
  );

  always #5 clk = ~clk;

  // Game model: board of marks, cursor, whose turn, and a pending-judgement flag
  int m_board[9];
  int m_cell   = 0;
  int m_turn   = 1;
  int m_win    = 0;
  int m_count  = 0;
  int m_k      = 0;
  bit m_over   = 1'b0;
  bit m_pend   = 1'b0;
  int lines[8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                      '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

  function automatic bit m_has_line(input int mark);
    for (int l = 0; l < 8; l++) begin
      if (m_board[lines[l][0]] == mark && m_board[lines[l][1]] == mark &&
          m_board[lines[l][2]] == mark) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 9; i++) m_board[i] = 0;
    m_cell = 0; m_turn = int'(FP); m_win = 0; m_over = 1'b0;
    m_pend = 1'b0; m_count = 0;
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_clear();
      m_k = 0;
    end else begin
      m_k++;
      if (restart) begin
        m_clear();
      end else if (m_pend) begin
        m_pend = 1'b0;
        if (m_has_line(m_turn)) begin
          m_win = m_turn; m_over = 1'b1;
        end else if (m_count == 9) begin
          m_win = 0; m_over = 1'b1;
        end else begin
          m_turn = 3 - m_turn;
        end
      end else if (!m_over) begin
        if (place) begin
          if (m_board[m_cell] == 0) begin
            m_board[m_cell] = m_turn;
            m_count++;
            m_pend = 1'b1;
          end
        end else if (move_next && !move_prev) begin
          m_cell = (m_cell + 1) % 9;
        end else if (move_prev && !move_next) begin
          m_cell = (m_cell + 8) % 9;
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cell", int'(currentCell), m_cell);
      for (int i = 0; i < 9; i++) chk($sformatf("board%0d", i), int'(currentGame[i]), m_board[i]);
      chk("turn", int'(turn), m_turn);
      chk("winner", int'(winner), m_win);
      chk("game_over", int'(game_over), int'(m_over));
      chk("blink", int'(cursor_blink), (m_k / int'(BDIV)) % 2);
    end
  end

  task automatic tick(input logic mn, input logic mp, input logic pl, input logic rs);
    move_next = mn; move_prev = mp; place = pl; restart = rs;
    @(posedge clk);
    #2;
    move_next = 1'b0; move_prev = 1'b0; place = 1'b0; restart = 1'b0;
  endtask

  task automatic goto(input int t);
    for (int n = 0; n < 9 && m_cell != t; n++) tick(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic play(input int c);
    goto(c);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #1 reset = 1'b0;
    cmp_en = 1'b1;
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    chk("rst_cell", int'(currentCell), 0);
    chk("rst_board", int'(currentGame), 0);
    chk("rst_turn", int'(turn), 1);
    chk("rst_winner", int'(winner), 0);
    chk("rst_over", int'(game_over), 0);
    chk("rst_blink", int'(cursor_blink), 0);

    repeat (3) tick(1'b0, 1'b0, 1'b0, 1'b0);
    chk("blink_c3", int'(cursor_blink), 0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    chk("blink_c4", int'(cursor_blink), 1);
    repeat (3) tick(1'b0, 1'b0, 1'b0, 1'b0);
    chk("blink_c7", int'(cursor_blink), 1);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    chk("blink_c8", int'(cursor_blink), 0);

    tick(1'b0, 1'b1, 1'b0, 1'b0);
    chk("prev_wrap", int'(currentCell), 8);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    chk("next_wrap", int'(currentCell), 0);
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    chk("both_hold", int'(currentCell), 0);

    tick(1'b0, 1'b0, 1'b1, 1'b0);
    chk("place_board", int'(currentGame[0]), 1);
    chk("place_turn_1cyc", int'(turn), 1);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    chk("place_turn_2cyc", int'(turn), 2);
    chk("place_over", int'(game_over), 0);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    chk("occupied_board", int'(currentGame[0]), 1);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    chk("occupied_turn", int'(turn), 2);

    tick(1'b0, 1'b0, 1'b0, 1'b1);
    chk("restart_board", int'(currentGame), 0);
    chk("restart_turn", int'(turn), 1);

    play(0); play(3); play(1); play(4); play(2);
    chk("xwin_winner", int'(winner), 1);
    chk("xwin_over", int'(game_over), 1);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    chk("over_cell", int'(currentCell), 2);
    chk("over_board", int'(currentGame), 661);
    chk("over_turn", int'(turn), 1);

    tick(1'b0, 1'b0, 1'b0, 1'b1);
    play(0); play(1); play(2); play(4); play(3); play(5); play(7); play(6); play(8);
    chk("draw_winner", int'(winner), 0);
    chk("draw_over", int'(game_over), 1);

    tick(1'b0, 1'b0, 1'b0, 1'b1);
    play(0); play(2); play(1); play(4); play(8); play(6);
    chk("odiag_winner", int'(winner), 2);
    chk("odiag_over", int'(game_over), 1);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    chk("rs_board", int'(currentGame), 0);
    chk("rs_turn", int'(turn), 1);
    chk("rs_over", int'(game_over), 0);
    chk("rs_cell", int'(currentCell), 0);
    chk("rs_winner", int'(winner), 0);

    play(4);
    goto(0);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    reset = 1'b0;
    #1;
    chk("async_cell", int'(currentCell), 0);
    chk("async_board", int'(currentGame), 0);
    chk("async_turn", int'(turn), 1);
    chk("async_winner", int'(winner), 0);
    chk("async_over", int'(game_over), 0);
    chk("async_blink", int'(cursor_blink), 0);
    @(posedge clk);
    #3 reset = 1'b1;
    repeat (3) tick(1'b0, 1'b0, 1'b0, 1'b0);
    chk("post_async_board", int'(currentGame), 0);
    chk("post_async_turn", int'(turn), 1);

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ttt_game_ctrl.md
Name: ttt_game_ctrl

Overview:
Tic-tac-toe game controller. It sits directly upstream of the LED cell renderer and owns the cursor position, the 9-cell board state and turn alternation. It also runs a win/draw check and a cursor blink strobe. Its outputs currentCell and currentGame feed the renderer's inputs of the same name unchanged.

Parameters:
FIRST_PLAYER, 2'b01, mark that moves first after reset/restart (2'b01 = X, 2'b10 = O).
BLINK_DIV, 25_000_000, clk cycles per half-period of cursor_blink; legal range 1 to 2^26-1.

Ports:
clk  input  1  system clock; all state updates on its rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
move_next  input  1  single-cycle pulse; advance cursor by one cell.
move_prev  input  1  single-cycle pulse; retreat cursor by one cell.
place  input  1  single-cycle pulse; place current player's mark at cursor.
restart  input  1  single-cycle pulse; clear board, start a new game.
currentCell  output  4  cursor cell index, 0..8, row-major (0 = top-left).
currentGame  output  [8:0][1:0]  board; per cell 00 empty, 01 X, 10 O; 11 never driven.
turn  output  2  mark of the player to move (01 or 10).
winner  output  2  00 none or draw, 01 X won, 10 O won.
game_over  output  1  high while in OVER state.
cursor_blink  output  1  free-running square wave, toggles every BLINK_DIV cycles.

Behaviour:
- Inputs are pre-debounced and edge-detected upstream. Pulses wider than one cycle act once per cycle high.
- Reset (reset==0, async): currentCell=0, currentGame all 00, turn=FIRST_PLAYER, winner=00, game_over=0, cursor_blink=0, blink counter=0, move count=0, state=PLAY.
- State machine has three states: PLAY, CHECK, OVER.
- PLAY:
  - Priority order is restart > place > move.
  - place with currentGame[currentCell]==00: write turn into that cell, increment move count (0..9), go to CHECK next cycle. Cursor does not move that cycle.
  - place on an occupied cell: ignored. No state, turn or count change.
  - move_next: currentCell wraps 8 to 0. move_prev: wraps 0 to 8.
  - move_next and move_prev high together: cursor holds.
- CHECK (exactly one cycle; all inputs except restart ignored):
  - Evaluate the 8 lines (rows 0-1-2, 3-4-5, 6-7-8; columns 0-3-6, 1-4-7, 2-5-8; diagonals 0-4-8, 2-4-6) against the mark just placed.
  - Any line fully matches: winner=that mark, game_over=1, go to OVER. turn is not toggled.
  - Else move count==9: winner=00, game_over=1, go to OVER (draw).
  - Else toggle turn (01 and 10 swap), return to PLAY.
- OVER: board, winner and cursor frozen. move_next, move_prev and place are ignored.
- restart (any state): next cycle board all 00, turn=FIRST_PLAYER, winner=00, game_over=0, move count=0, currentCell=0, state=PLAY. The blink counter is not affected.
- The win check is a combinational reduction of registered currentGame. All outputs are registered; no output depends combinationally on inputs.
- Latency:
  - place to currentGame update: 1 cycle.
  - place to winner/game_over/turn update: 2 cycles.
  - move to currentCell update: 1 cycle.
- Blink counter counts 0..BLINK_DIV-1 continuously in all states. At terminal count it wraps to 0 and cursor_blink toggles.
- Width rules: currentCell never leaves 0..8. A cell is never written to 11. move count saturates at 9.
- Async reset asserted mid-CHECK or in OVER: full reset values immediately; no partial write persists.

Test Plan:
- Reset, then move_prev once -> currentCell=8. Then move_next once -> currentCell=0. move_next and move_prev in the same cycle -> currentCell unchanged.
- From reset, place at 0 -> 1 cycle later currentGame[0]=01. 2 cycles later turn=10, game_over=0. place at 0 again -> no change to board or turn.
- Sequence X:0, O:3, X:1, O:4, X:2 -> 2 cycles after the last place, winner=01 and game_over=1. Then place or moves -> board and currentCell unchanged.
- Sequence X:0,O:1,X:2,O:4,X:3,O:5,X:7,O:6,X:8 (no line) -> winner=00, game_over=1 after the ninth move.
- Diagonal win for O (X:0,O:2,X:1,O:4,X:8,O:6) -> winner=10. Then restart -> next cycle all cells 00, turn=01, game_over=0, currentCell=0.
- BLINK_DIV=4 -> cursor_blink toggles every 4 cycles, 8-cycle period, unaffected by restart. Async reset pulse mid-game -> all outputs at reset values without waiting for a clk edge.
